c_boot_loader: RTL and testbench

//   Boot-image loader feeding c_clgen. After reset it copies WORD_COUNT words from the boot ROM

---
 rtl/c_boot_loader.sv | 128 ++++++++++++
 tb/tb_c_boot_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_boot_loader.sv
// Boot-image loader: copies WORD_COUNT ROM words into program RAM after reset,
// then flags load_done, checksum_ok, or load_error on a stuck RAM write port.
module c_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ROM_AW = 10,
    parameter int RAM_AW = 14,
    parameter int WORD_COUNT = 1024,
    parameter int RAM_BASE = 0,
    parameter logic [DATA_WIDTH-1:0] EXPECTED_SUM = '0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  rom_en_o,
    output logic [ROM_AW-1:0]     rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  ram_we_o,
    output logic [RAM_AW-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic                  ram_ack_i,
    output logic                  load_done,
    output logic                  checksum_ok,
    output logic                  load_error,
    output logic [ROM_AW:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(WORD_COUNT - 1);
    localparam logic [15:0]       TMO_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [RAM_AW-1:0] BASE     = RAM_AW'(RAM_BASE);

    state_t                  state;
    logic [ROM_AW-1:0]       idx;
    logic [DATA_WIDTH-1:0]   sum;
    logic [15:0]             timer;

    // ram_data_o doubles as the write buffer; it is only updated in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            sum          <= '0;
            timer        <= '0;
            rom_en_o     <= 1'b0;
            rom_addr_o   <= '0;
            ram_we_o     <= 1'b0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            load_done    <= 1'b0;
            checksum_ok  <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    rom_en_o   <= 1'b1;
                    rom_addr_o <= idx;
                    state      <= S_READ;
                end
                S_READ: begin
                    rom_en_o <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    ram_data_o <= rom_data_i;
                    ram_addr_o <= BASE + RAM_AW'(idx);
                    ram_we_o   <= 1'b1;
                    timer      <= '0;
                    state      <= S_WRITE;
                end
                S_WRITE: begin
                    // An ack coinciding with the last timeout cycle still counts.
                    if (ram_ack_i) begin
                        ram_we_o     <= 1'b0;
                        sum          <= sum + ram_data_o;
                        words_loaded <= {1'b0, idx} + (ROM_AW + 1)'(1);
                        timer        <= '0;
                        if (idx == LAST_IDX) begin
                            state <= S_CHECK;
                        end else begin
                            idx        <= idx + ROM_AW'(1);
                            rom_en_o   <= 1'b1;
                            rom_addr_o <= idx + ROM_AW'(1);
                            state      <= S_READ;
                        end
                    end else if (timer == TMO_LAST) begin
                        ram_we_o   <= 1'b0;
                        load_error <= 1'b1;
                        timer      <= '0;
                        state      <= S_ERROR;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_CHECK: begin
                    checksum_ok <= (sum == EXPECTED_SUM);
                    load_done   <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE, S_ERROR: begin
                    if (start_i) begin
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        checksum_ok  <= 1'b0;
                        idx          <= '0;
                        sum          <= '0;
                        words_loaded <= '0;
                        rom_en_o     <= 1'b1;
                        rom_addr_o   <= '0;
                        state        <= S_READ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c_boot_loader.sv
// Scoreboard bench for c_boot_loader: expected RAM writes are queued by the
// stimulus and popped by per-DUT monitors on each acknowledged write.
module tb_c_boot_loader;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT A: 4 words, base 0, expected sum 10, short ack timeout
    logic        rst, a_start, a_rom_en, a_we, a_ack;
    logic [9:0]  a_rom_addr;
    logic [31:0] a_rom_data, a_data;
    logic [13:0] a_addr;
    logic        a_done, a_ok, a_err;
    logic [10:0] a_wl;
    logic [31:0] rom_a [4];

    c_boot_loader #(
        .DATA_WIDTH(32), .ROM_AW(10), .RAM_AW(14), .WORD_COUNT(4),
        .RAM_BASE(0), .EXPECTED_SUM(32'd10), .ACK_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start),
        .rom_en_o(a_rom_en), .rom_addr_o(a_rom_addr), .rom_data_i(a_rom_data),
        .ram_we_o(a_we), .ram_addr_o(a_addr), .ram_data_o(a_data),
        .ram_ack_i(a_ack), .load_done(a_done), .checksum_ok(a_ok),
        .load_error(a_err), .words_loaded(a_wl)
    );

    always @(posedge clk)
        if (a_rom_en) a_rom_data <= rom_a[a_rom_addr[1:0]];

    // DUT B: wrapping RAM address and overflowing sum
    logic        rst_b, b_start, b_rom_en, b_we, b_ack;
    logic [9:0]  b_rom_addr;
    logic [31:0] b_rom_data, b_data;
    logic [13:0] b_addr;
    logic        b_done, b_ok, b_err;
    logic [10:0] b_wl;

    c_boot_loader #(
        .DATA_WIDTH(32), .ROM_AW(10), .RAM_AW(14), .WORD_COUNT(4),
        .RAM_BASE(16382), .EXPECTED_SUM(32'hFFFF_FFFC), .ACK_TIMEOUT(255)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start_i(b_start),
        .rom_en_o(b_rom_en), .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data),
        .ram_we_o(b_we), .ram_addr_o(b_addr), .ram_data_o(b_data),
        .ram_ack_i(b_ack), .load_done(b_done), .checksum_ok(b_ok),
        .load_error(b_err), .words_loaded(b_wl)
    );

    always @(posedge clk)
        if (b_rom_en) b_rom_data <= 32'hFFFF_FFFF;

    wr_t qa[$];
    wr_t qb[$];

    bit   ack_never = 0;
    int   delay_addr = -1;
    int   ack_delay = 0;
    int   a_run = 0;
    int   held = 0;
    logic [13:0] a_paddr;
    logic [31:0] a_pdata;

    // Monitor A: drives ack, checks hold stability and scoreboard order.
    always @(negedge clk) begin
        wr_t e;
        if (a_we) a_run = a_run + 1;
        else a_run = 0;
        a_ack = a_we && !ack_never &&
                !(int'(a_addr) == delay_addr && a_run <= ack_delay);
        if (a_we && a_run > 1) begin
            check("hold_addr", 64'(a_addr), 64'(a_paddr));
            check("hold_data", 64'(a_data), 64'(a_pdata));
        end
        if (a_we && qa.size() > 0)
            check("words_loaded", 64'(a_wl), 64'(qa[0].addr));
        if (a_we && a_ack) begin
            if (int'(a_addr) == delay_addr) held = a_run;
            if (qa.size() == 0) begin
                check("a_extra_write", 64'(1), 64'(0));
            end else begin
                e = qa.pop_front();
                check("a_wr_addr", 64'(a_addr), 64'(e.addr));
                check("a_wr_data", 64'(a_data), 64'(e.data));
            end
        end
        a_paddr = a_addr;
        a_pdata = a_data;
    end

    always @(negedge clk) begin
        wr_t e;
        b_ack = b_we;
        if (b_we) begin
            if (qb.size() == 0) begin
                check("b_extra_write", 64'(1), 64'(0));
            end else begin
                e = qb.pop_front();
                check("b_wr_addr", 64'(b_addr), 64'(e.addr));
                check("b_wr_data", 64'(b_data), 64'(e.data));
            end
        end
    end

    task automatic push_a4(logic [31:0] d3);
        qa.push_back('{14'd0, 32'd1});
        qa.push_back('{14'd1, 32'd2});
        qa.push_back('{14'd2, 32'd3});
        qa.push_back('{14'd3, d3});
    endtask

    task automatic wait_done_a(output int n);
        n = 401;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (a_done || a_err) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_start;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    int n;
    int we_cnt;

    initial begin
        rst = 1'b1;
        rst_b = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        a_ack = 1'b0;
        b_ack = 1'b0;
        rom_a = '{32'd1, 32'd2, 32'd3, 32'd4};
        repeat (2) @(negedge clk);
        check("reset_ctrl",
              64'({a_rom_en, a_we, a_done, a_ok, a_err, a_wl, a_rom_addr}),
              64'(0));
        check("reset_data", 64'({a_addr, a_data}), 64'(0));

        // basic copy, ack every cycle, latency from reset release
        push_a4(32'd4);
        rst = 1'b0;
        wait_done_a(n);
        check("done_latency", 64'(n), 64'(14));
        check("t1_ok", 64'({a_done, a_ok, a_err}), 64'(3'b110));
        check("t1_words", 64'(a_wl), 64'(4));

        // checksum mismatch after restart
        rom_a[3] = 32'd5;
        push_a4(32'd5);
        pulse_start();
        check("restart_clears_done", 64'(a_done), 64'(0));
        wait_done_a(n);
        check("restart_latency", 64'(n), 64'(13));
        check("t2_bad_sum", 64'({a_done, a_ok, a_err}), 64'(3'b100));

        // delayed ack on word 2
        rom_a[3] = 32'd4;
        delay_addr = 2;
        ack_delay = 5;
        push_a4(32'd4);
        pulse_start();
        wait_done_a(n);
        check("t3_held_cycles", 64'(held), 64'(6));
        check("t3_ok", 64'({a_done, a_ok, a_err}), 64'(3'b110));
        check("t3_words", 64'(a_wl), 64'(4));
        delay_addr = -1;

        // ack timeout, then restart
        ack_never = 1;
        pulse_start();
        we_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_err) break;
            if (a_we) we_cnt++;
        end
        check("t4_we_cycles", 64'(we_cnt), 64'(8));
        check("t4_err", 64'({a_done, a_err, a_we, a_rom_en}), 64'(4'b0100));
        check("t4_words", 64'(a_wl), 64'(0));
        repeat (3) @(negedge clk);
        check("t4_sticky", 64'({a_err, a_we}), 64'(2'b10));
        ack_never = 0;
        push_a4(32'd4);
        pulse_start();
        check("t4_err_cleared", 64'(a_err), 64'(0));
        wait_done_a(n);
        check("t4_recover", 64'({a_done, a_ok, a_err}), 64'(3'b110));

        // reset mid-copy after two writes
        qa.push_back('{14'd0, 32'd1});
        qa.push_back('{14'd1, 32'd2});
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (a_wl == 11'd2) break;
            @(negedge clk);
        end
        check("t5_two_written", 64'(a_wl), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        check("t5_abort_ctrl",
              64'({a_rom_en, a_we, a_done, a_ok, a_err, a_wl, a_rom_addr}),
              64'(0));
        check("t5_abort_data", 64'({a_addr, a_data}), 64'(0));
        check("t5_queue", 64'(qa.size()), 64'(0));
        push_a4(32'd4);
        rst = 1'b0;
        wait_done_a(n);
        check("t5_latency", 64'(n), 64'(14));
        check("t5_ok", 64'({a_done, a_ok, a_err}), 64'(3'b110));

        // address wrap and sum overflow
        qb.push_back('{14'd16382, 32'hFFFF_FFFF});
        qb.push_back('{14'd16383, 32'hFFFF_FFFF});
        qb.push_back('{14'd0, 32'hFFFF_FFFF});
        qb.push_back('{14'd1, 32'hFFFF_FFFF});
        rst_b = 1'b0;
        n = 401;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (b_done || b_err) begin
                n = i;
                break;
            end
        end
        check("t6_latency", 64'(n), 64'(14));
        check("t6_ok", 64'({b_done, b_ok, b_err}), 64'(3'b110));
        check("t6_words", 64'(b_wl), 64'(4));

        repeat (2) @(negedge clk);
        check("a_queue_empty", 64'(qa.size()), 64'(0));
        check("b_queue_empty", 64'(qb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
